// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared lane-layout constants, drain FSM states and helpers
//               for the MAC accumulator drain datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam logic MODE_INT4 = 1'b0;
    localparam logic MODE_INT8 = 1'b1;

    localparam int LANES_INT8 = 4;
    localparam int LANES_INT4 = 8;
    localparam int LW_INT8    = 32;
    localparam int LW_INT4    = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Index of the final lane in a word of the given layout.
    function automatic logic [2:0] last_lane(input logic mode);
        return (mode == MODE_INT8) ? 3'(LANES_INT8 - 1) : 3'(LANES_INT4 - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane_sel
// Description : Picks one lane from a packed accumulator word and widens it
//               to 32 bits (INT4 lanes are sign-extended).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_sel
    import mac_pkg::*;
#(
    parameter int ACC_W = 128
) (
    input  logic [ACC_W-1:0] word,
    input  logic             mode,
    input  logic [2:0]       lane,
    output logic [31:0]      value
);

    logic [LW_INT8-1:0] w_wide;
    logic [LW_INT4-1:0] w_half;

    assign w_wide = word[{lane[1:0], 5'b00000} +: LW_INT8];
    assign w_half = word[{lane, 4'b0000} +: LW_INT4];

    always_comb begin
        value = '0;
        if (mode == MODE_INT8) begin
            value = w_wide;
        end else begin
            value = {{(32 - LW_INT4){w_half[LW_INT4-1]}}, w_half};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_int_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_int_drain
// Description : Accepts a packed INT8/INT4 accumulator word and serializes
//               its lanes one per cycle onto a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_int_drain
    import mac_pkg::*;
#(
    parameter int ACC_W = 128,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [ACC_W-1:0] in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_lane,
    output logic             out_last
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_mode;
    logic [2:0]       r_lane;
    logic [31:0]      w_lane_val;
    logic             w_is_last;
    logic             w_in_xfer;
    logic             w_out_xfer;

    mac_lane_sel #(
        .ACC_W (ACC_W)
    ) u_lane_sel (
        .word  (r_acc),
        .mode  (r_mode),
        .lane  (r_lane),
        .value (w_lane_val)
    );

    assign w_is_last  = (r_lane == last_lane(r_mode));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Outputs are forced quiet while rst is high so nothing leaks during reset.
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_lane    = '0;
        out_last    = 1'b0;
        in_ready    = 1'b0;
        w_state_nxt = r_state;
        if (!rst) begin
            out_valid = (r_state == ST_DRAIN);
            out_data  = OUT_W'(w_lane_val);
            out_lane  = r_lane;
            out_last  = w_is_last;
            in_ready  = (r_state == ST_IDLE) ||
                        (out_valid && w_is_last && out_ready);
        end
        case (r_state)
            ST_IDLE: begin
                if (w_in_xfer) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_out_xfer && w_is_last)
                    w_state_nxt = w_in_xfer ? ST_DRAIN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_mode  <= MODE_INT4;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_xfer) begin
                r_acc  <= in_acc;
                r_mode <= in_mode;
                r_lane <= '0;
            end else if (w_out_xfer && !w_is_last) begin
                r_lane <= r_lane + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire
